// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks.
// Functions work on zero-extended values, so any width up to MAX_W fits.
package fifo_pkg;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Full when the two top Gray bits differ and the rest match.
  function automatic logic full_match(
    input logic [MAX_W-1:0] wg,
    input logic [MAX_W-1:0] rg,
    input int unsigned      w
  );
    return wg == (rg ^ (32'd3 << (w - 2)));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for Gray-coded pointers.
// Synchronous active-high reset.
module sync_2ff #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q1;
  logic [W-1:0] r_q2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full, level and overflow
// for the dual-clock FIFO, all in the w_clk domain.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE       = 5,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic                    w_en,
  input  logic [ADDRESS_SIZE:0]   r_ptr_gray,
  output logic [ADDRESS_SIZE-1:0] w_adrs,
  output logic [ADDRESS_SIZE:0]   w_ptr_gray,
  output logic                    w_accept,
  output logic                    full,
  output logic                    almost_full,
  output logic [ADDRESS_SIZE:0]   w_level,
  output logic                    overflow
);

  localparam int PW = ADDRESS_SIZE + 1;
  localparam int D  = 1 << ADDRESS_SIZE;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t AF_TH = ptr_t'(D - ALMOST_FULL_MARGIN);

  ptr_t r_wbin;
  ptr_t r_wgray;
  ptr_t w_rq2;
  ptr_t w_rbin_s;
  ptr_t w_wbin_next;
  ptr_t w_wgray_next;
  ptr_t w_level_next;
  logic w_push;
  logic w_full_next;

  sync_2ff #(
    .W (PW)
  ) u_rsync (
    .i_clk (w_clk),
    .i_rst (w_rst),
    .i_d   (r_ptr_gray),
    .o_q   (w_rq2)
  );

  assign w_push       = w_en & ~full;
  assign w_wbin_next  = r_wbin + {{ADDRESS_SIZE{1'b0}}, w_push};
  assign w_wgray_next = ptr_t'(bin2gray(MAX_W'(w_wbin_next)));
  assign w_rbin_s     = ptr_t'(gray2bin(MAX_W'(w_rq2)));
  assign w_level_next = w_wbin_next - w_rbin_s;
  assign w_full_next  = full_match(MAX_W'(w_wgray_next),
                                   MAX_W'(w_rq2), PW);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_wbin      <= '0;
      r_wgray     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
      overflow    <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      r_wgray     <= w_wgray_next;
      full        <= w_full_next;
      almost_full <= (w_level_next >= AF_TH);
      w_level     <= w_level_next;
      overflow    <= overflow | (w_en & full);
    end
  end

  assign w_adrs     = r_wbin[ADDRESS_SIZE-1:0];
  assign w_ptr_gray = r_wgray;
  assign w_accept   = w_push;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full.
// Table vectors, directed corners and a random run against a count model.
module tb_fifo_wptr_full;

  localparam int AW = 5;
  localparam int PW = 6;
  localparam int D  = 32;
  localparam int M  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] rg;
  logic [AW-1:0] adrs;
  logic [PW-1:0] wg;
  logic          acc;
  logic          full;
  logic          af;
  logic [PW-1:0] lvl;
  logic          ov;

  fifo_wptr_full #(
    .ADDRESS_SIZE       (AW),
    .ALMOST_FULL_MARGIN (M)
  ) dut (
    .w_clk       (clk),
    .w_rst       (rst),
    .w_en        (en),
    .r_ptr_gray  (rg),
    .w_adrs      (adrs),
    .w_ptr_gray  (wg),
    .w_accept    (acc),
    .full        (full),
    .almost_full (af),
    .w_level     (lvl),
    .overflow    (ov)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  int m_w;
  int m_lvl;
  bit m_full;
  bit m_af;
  bit m_ov;
  int rq[$];
  int rb;
  int cyc = 0;
  bit last_acc;
  logic [PW-1:0] prev_g;

  typedef struct {
    bit en;
    int adrs;
    int lvl;
    int gray;
    bit full;
    bit af;
    bit ov;
    bit acc;
  } vec_t;

  vec_t tbl[35];

  function automatic int g(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
  endtask

  task automatic step(input bit r, input bit e, input int rbin);
    int seen;
    bit p;
    rst = r;
    en  = e;
    rb  = rbin % 64;
    rg  = PW'(g(rb));
    #1;
    last_acc = acc;
    check("accept", int'(acc), int'(e & ~m_full));
    @(posedge clk);
    cyc++;
    if (r) begin
      m_w = 0; m_lvl = 0;
      m_full = 0; m_af = 0; m_ov = 0;
      rq = {0, 0};
    end else begin
      p = e && !m_full;
      m_ov = m_ov | (e && m_full);
      m_w = (m_w + int'(p)) % 64;
      seen = rq.pop_front();
      rq.push_back(rb);
      m_lvl = (m_w - seen + 64) % 64;
      m_full = (m_lvl == D);
      m_af = (m_lvl >= D - M);
    end
    #1;
    check("adrs", int'(adrs), m_w % D);
    check("gray", int'(wg), g(m_w));
    check("full", int'(full), int'(m_full));
    check("afull", int'(af), int'(m_af));
    check("level", int'(lvl), m_lvl);
    check("ovf", int'(ov), int'(m_ov));
    if (!r) check("gray_1bit", int'($countones(wg ^ prev_g) <= 1), 1);
    prev_g = wg;
  endtask

  initial begin
    int rp;
    rq = {0, 0};
    m_full = 0;
    prev_g = '0;
    for (int i = 0; i < 35; i++) begin
      int n;
      n = (i + 1 > D) ? D : i + 1;
      tbl[i].en   = 1'b1;
      tbl[i].adrs = n % D;
      tbl[i].lvl  = n;
      tbl[i].gray = g(n);
      tbl[i].full = (n == D);
      tbl[i].af   = (n >= D - M);
      tbl[i].ov   = (i >= D);
      tbl[i].acc  = (i < D);
    end

    step(1, 0, 0);
    check("rst_adrs", int'(adrs), 0);
    check("rst_level", int'(lvl), 0);
    check("rst_full", int'(full), 0);
    check("rst_gray", int'(wg), 0);
    step(0, 0, 0);

    for (int i = 0; i < 35; i++) begin
      step(0, tbl[i].en, 0);
      check("t_acc", int'(last_acc), int'(tbl[i].acc));
      check("t_adrs", int'(adrs), tbl[i].adrs);
      check("t_lvl", int'(lvl), tbl[i].lvl);
      check("t_gray", int'(wg), tbl[i].gray);
      check("t_full", int'(full), int'(tbl[i].full));
      check("t_af", int'(af), int'(tbl[i].af));
      check("t_ov", int'(ov), int'(tbl[i].ov));
    end

    step(0, 0, 1);
    check("pop_e0_full", int'(full), 1);
    step(0, 0, 1);
    check("pop_e1_full", int'(full), 1);
    check("pop_e1_lvl", int'(lvl), 32);
    step(0, 0, 1);
    check("pop_e2_full", int'(full), 0);
    check("pop_e2_lvl", int'(lvl), 31);

    for (int i = 0; i < 3; i++) step(0, 0, 22);
    check("lvl10", int'(lvl), 10);
    step(0, 0, 23);
    step(0, 0, 24);
    for (int k = 0; k < 70; k++) begin
      rp = 25 + k;
      step(0, 1, rp);
      check("steady_lvl", int'(lvl), 10);
      check("wrap_nofull", int'(full), 0);
    end

    rp = rb;
    for (int k = 0; k < 400; k++) begin
      if (($urandom % 3) == 0 && rp != m_w) rp = (rp + 1) % 64;
      step(0, ($urandom % 4) != 0, rp);
    end

    check("ov_sticky", int'(ov), 1);
    step(1, 1, 0);
    check("mrst_adrs", int'(adrs), 0);
    check("mrst_gray", int'(wg), 0);
    check("mrst_lvl", int'(lvl), 0);
    check("mrst_ov", int'(ov), 0);
    check("mrst_full", int'(full), 0);
    step(0, 0, 0);
    check("mrst_noadv", int'(adrs), 0);
    step(0, 1, 0);
    check("post_push", int'(adrs), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and flag controller for the asynchronous FIFO, sitting directly upstream of the dual-clock FIFO RAM in the `w_clk` domain. It:
- accepts write requests and generates the RAM write address;
- publishes a Gray-coded write pointer to the read domain;
- synchronises the read domain's Gray pointer with a 2-flop synchroniser;
- produces registered `full`, `almost_full`, fill level and a sticky overflow flag.

The RAM is instantiated with `ADDRESS_SIZE` = this block's `ADDRESS_SIZE` and `MEM_DEPTH` = 2**`ADDRESS_SIZE`. It is fed `w_adrs`, `full` and `w_en`.

## Interface
- `ADDRESS_SIZE`, 5, RAM address width; FIFO depth D = 2**`ADDRESS_SIZE`.
- `ALMOST_FULL_MARGIN`, 4, `almost_full` asserts when level >= D − margin; legal range 1..D−1.
- `w_clk` input 1, write-domain clock; all logic on rising edge.
- `w_rst` input 1, reset, synchronous, active-high.
- `w_en` input 1, write request for this cycle.
- `r_ptr_gray` input `ADDRESS_SIZE`+1, read pointer (Gray), asynchronous to `w_clk`.
- `w_adrs` output `ADDRESS_SIZE`, RAM write address (low bits of binary write pointer).
- `w_ptr_gray` output `ADDRESS_SIZE`+1, registered Gray write pointer to the read domain.
- `w_accept` output 1, combinational `w_en & ~full`; the write is committed this cycle.
- `full` output 1, registered full flag.
- `almost_full` output 1, registered.
- `w_level` output `ADDRESS_SIZE`+1, registered conservative occupancy, 0..D.
- `overflow` output 1, sticky; set when `w_en & full`.

## Operation
- State:
  - binary write pointer `wbin` (`ADDRESS_SIZE`+1 bits);
  - `w_ptr_gray`;
  - sync stages `rq1` and `rq2` holding `r_ptr_gray`;
  - `full`, `almost_full`, `w_level`, `overflow`.
- Push: `push` = `w_en & ~full`.
  - `wbin_next` = `wbin` + `push`, wrapping modulo 2**(`ADDRESS_SIZE`+1).
  - `wgray_next` = `wbin_next` ^ (`wbin_next` >> 1).
- `w_adrs` = `wbin`[`ADDRESS_SIZE`−1:0]. The RAM writes at the current address on the edge where `push` = 1.
- Synchroniser: `rq1` <= `r_ptr_gray`, then `rq2` <= `rq1`. Only `rq2` is used by logic.
- Sync read pointer in binary: `rbin_s` = Gray-to-binary(`rq2`).
- Full: `full` <= (`wgray_next` == {~`rq2`[MSB:MSB−1], `rq2`[MSB−2:0]}).
- Level: `w_level` <= `wbin_next` − `rbin_s`, modulo 2**(`ADDRESS_SIZE`+1). The result is always 0..D.
- Almost full: `almost_full` <= (`wbin_next` − `rbin_s`) >= D − `ALMOST_FULL_MARGIN`.
- Overflow: `overflow` <= `overflow` | (`w_en` & `full`). Cleared only by reset. A write attempted while `full` = 1 is dropped: pointer unchanged, RAM not written.
- Flags are conservative. Read-side pops become visible after the sync latency, so `full`, `almost_full` and `w_level` may overstate occupancy but never understate it.

## Timing
- Reset (`w_rst` = 1 at an edge) sets all of the following to 0 at that edge: `wbin`, `w_ptr_gray`, `w_adrs`, `rq1`, `rq2`, `full`, `almost_full`, `w_level`, `overflow`. `w_accept` = `w_en` during and after reset, since `full` = 0.
- Reset has priority over push. `w_en` in a reset cycle is ignored (no pointer advance).
- Push latency:
  - a push in cycle N updates `w_adrs`, `w_ptr_gray`, `full`, `almost_full` and `w_level` at the edge ending cycle N;
  - the D-th consecutive push with no reads drives `full` = 1 at the edge ending that push, so cycle N+1 already blocks.
- Read-pointer latency: a change on `r_ptr_gray` before edge E reaches `rq2` at edge E+1. The flags reflect it at edge E+2.
- Simultaneous push and read-pointer advance: both are applied in the same next-state computation, so the level is unchanged.
- `w_ptr_gray` changes by at most one bit per `w_clk` edge. Required for safe capture in the read domain.
- Reset mid-operation clears only write-domain state. The read domain is reset concurrently at system level. Between the two resets, `full` / `w_level` reflect whatever `r_ptr_gray` shows; no recovery logic is required.

## Structure
- Shared package `fifo_pkg`:
  - Gray/binary conversion functions `bin2gray` and `gray2bin`, parameterised by width;
  - the full-compare helper, reused by the read-side block.
- One sub-module, `sync_2ff`: a width-parameterised 2-flop synchroniser with synchronous active-high reset, also used by the read side.

## Test plan
- Reset with `r_ptr_gray` = 0, then 32 back-to-back `w_en`:
  - `w_adrs` steps 0..31 then wraps to 0;
  - `almost_full` rises after the 28th push (level 28);
  - `full` rises after the 32nd push, `w_level` = 32;
  - `w_accept` = 0 on the 33rd cycle.
- While full, hold `w_en` = 1 for 3 cycles: pointer and `w_adrs` frozen, `overflow` = 1 and remains 1 until `w_rst`.
- From full (`wbin` = 32), drive `r_ptr_gray` = `bin2gray`(1): `full` falls and `w_level` = 31 exactly 2 cycles later, not earlier.
- Push every cycle while `r_ptr_gray` advances 1 per cycle, from level 10: `w_level` stays 10 in steady state, `w_ptr_gray` shows a single-bit change per edge.
- Run through a full pointer wrap (64 pushes with matching reads): `full` is never falsely asserted at the MSB wrap of `wbin` 63→0.
- Assert `w_rst` mid-stream with `w_en` = 1: next edge shows all outputs 0 and the pointer did not advance.
